periph_bus_initiator: RTL and testbench
=======================================

Name: periph_bus_initiator

Overview:
- Single-outstanding initiator on the cluster peripheral interconnect (XBAR_PERIPH_BUS signal set, master side).
- Turns one command from a local engine (debug/boot sequencer, test DMA) into one peripheral-bus read or write, and returns the response.
- Drives cluster peripherals such as the control unit: EoC, fetch-enable and boot-address registers.
- Adds a response-timeout watchdog and detection of responses whose ID does not match.

Parameters:
- PER_ID_WIDTH, 5: width of per_id_o and per_r_id_i.
- MASTER_ID, 0: constant ID driven on per_id_o; must fit in PER_ID_WIDTH.
- TIMEOUT_CYCLES, 256: WAIT_RSP cycles before a timeout is declared; 0 disables the timeout.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- cmd_valid_i, in, 1: command valid.
- cmd_ready_o, out, 1: command accepted when valid & ready.
- cmd_wen_i, in, 1: 1 = read, 0 = write (bus convention).
- cmd_add_i, in, 32: target byte address.
- cmd_wdata_i, in, 32: write data.
- cmd_be_i, in, 4: byte enables.
- rsp_valid_o, out, 1: response valid.
- rsp_ready_i, in, 1: response consumed when valid & ready.
- rsp_rdata_o, out, 32: read data; 0 for writes and timeouts.
- rsp_err_o, out, 1: per_r_opc_i was 1, or a timeout occurred.
- rsp_timeout_o, out, 1: the response is due to a timeout.
- busy_o, out, 1: FSM not in IDLE.
- stray_rsp_o, out, 1: one-cycle pulse when a response with a mismatched ID, or any response outside WAIT_RSP, is seen.
- per_req_o, out, 1: bus request.
- per_add_o, out, 32: bus address.
- per_wen_o, out, 1: 1 = read, 0 = write.
- per_wdata_o, out, 32: bus write data.
- per_be_o, out, 4: bus byte enables.
- per_id_o, out, PER_ID_WIDTH: transaction ID.
- per_gnt_i, in, 1: grant.
- per_r_valid_i, in, 1: response valid.
- per_r_id_i, in, PER_ID_WIDTH: response ID.
- per_r_rdata_i, in, 32: response data.
- per_r_opc_i, in, 1: response error flag.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - FSM = IDLE.
  - All per_* outputs = 0; per_wen_o = 0.
  - rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o, stray_rsp_o = 0.
  - Timeout counter = 0.
- FSM states: IDLE, REQ, WAIT_RSP, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch wen/add/wdata/be into registers and go to REQ.
  - cmd_ready_o is 0 in every other state.
- REQ:
  - per_req_o = 1 and per_* fields are driven from the latched registers; all are stable until granted.
  - When per_gnt_i = 1, go to WAIT_RSP and clear the counter. per_req_o is 0 from the next cycle.
  - Otherwise stay in REQ. There is no timeout on grant.
- WAIT_RSP:
  - On per_r_valid_i with per_r_id_i == MASTER_ID: capture rdata (writes capture 0), set err = per_r_opc_i, timeout = 0, go to RESP.
  - On a mismatched ID: ignore the response, pulse stray_rsp_o, keep counting.
  - Otherwise, if TIMEOUT_CYCLES ≠ 0 and counter == TIMEOUT_CYCLES-1: rdata = 0, err = 1, timeout = 1, go to RESP.
  - Otherwise increment the counter.
  - A matching response in the timeout cycle wins over the timeout.
- RESP:
  - rsp_valid_o = 1; data, err and timeout are held stable.
  - When rsp_ready_i = 1, go to IDLE.
  - A new command is accepted no earlier than the cycle after the handshake.
- Latency: with zero-wait grant and r_valid in the cycle after grant, rsp_valid_o asserts 3 cycles after the cmd handshake.
  - Cycle 0: cmd accepted.
  - Cycle 1: REQ, granted.
  - Cycle 2: WAIT_RSP, r_valid.
  - Cycle 3: RESP.
- Responses outside WAIT_RSP: per_r_valid_i in IDLE, REQ, RESP, or in the grant cycle itself is ignored and pulses stray_rsp_o. The protocol places responses at least 1 cycle after grant.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter saturates and never wraps.
- Reset asserted mid-transaction (any state): return immediately to reset values and drop per_req_o. A late response after reset counts as stray.
- busy_o = (state ≠ IDLE), registered as the state decode.

Test Plan:
- Write, wen = 0, add = 0x1000_0018, wdata = 0x0000_1ABC, be = 0xF; slave gnt = 1 with r_valid next cycle → per_req_o high exactly 1 cycle with matching fields; rsp_valid_o at cmd + 3; rsp_err_o = 0; rsp_rdata_o = 0.
- Read, add = 0x1000_0040; gnt delayed 3 cycles; r_rdata = 0x1C00_0000 → per_req_o held 4 cycles with fields stable; rsp_rdata_o = 0x1C00_0000 at cmd + 6.
- TIMEOUT_CYCLES = 8; slave never responds → rsp_valid_o 8 cycles after entering WAIT_RSP, with rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
- MASTER_ID = 3; slave returns r_id = 5, then r_id = 3 two cycles later → one stray_rsp_o pulse; response taken from the r_id = 3 beat.
- rsp_ready_i held 0 for 5 cycles with cmd_valid_i = 1 → rsp fields stable, cmd_ready_o = 0 throughout; a new command is accepted the cycle after the handshake.
- rst_ni pulsed low in WAIT_RSP, then the slave's r_valid arrives after release → all outputs at reset values, FSM in IDLE, stray_rsp_o pulses once, no rsp_valid_o.

Source files
------------

// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator
//   Single-outstanding master on the cluster peripheral bus. Accepts one
//   command from a local engine and issues it as one bus read or write. It
//   then returns the bus response, or a timeout response if none arrives.
//   Responses with a foreign ID, and responses that arrive outside the
//   response window, are ignored and flagged on stray_rsp_o.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   cmd_*                       command channel (valid/ready)
//   rsp_*                       response channel (valid/ready), err/timeout flags
//   busy_o                      transaction in flight
//   stray_rsp_o                 one-cycle pulse, registered, for an ignored response
//   per_*                       peripheral bus master-side signals
module periph_bus_initiator #(
  parameter int PER_ID_WIDTH   = 5,
  parameter int MASTER_ID      = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_wen_i,
  input  logic [31:0]             cmd_add_i,
  input  logic [31:0]             cmd_wdata_i,
  input  logic [3:0]              cmd_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    busy_o,
  output logic                    stray_rsp_o,
  output logic                    per_req_o,
  output logic [31:0]             per_add_o,
  output logic                    per_wen_o,
  output logic [31:0]             per_wdata_o,
  output logic [3:0]              per_be_o,
  output logic [PER_ID_WIDTH-1:0] per_id_o,
  input  logic                    per_gnt_i,
  input  logic                    per_r_valid_i,
  input  logic [PER_ID_WIDTH-1:0] per_r_id_i,
  input  logic [31:0]             per_r_rdata_i,
  input  logic                    per_r_opc_i
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PER_ID_WIDTH-1:0] MID = PER_ID_WIDTH'(MASTER_ID);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_e;

  state_e            state, state_nxt;
  logic              wen_q;
  logic [31:0]       add_q, wdata_q;
  logic [3:0]        be_q;
  logic [CW-1:0]     cnt;
  logic [31:0]       rdata_q;
  logic              err_q, to_q, stray_q;
  logic              rsp_hit, to_hit;

  assign rsp_hit = per_r_valid_i && (per_r_id_i == MID);
  assign to_hit  = TO_EN && (cnt == CNT_LAST);

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state logic; a matching response beats a same-cycle timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (cmd_valid_i)       state_nxt = REQ;
      REQ:      if (per_gnt_i)         state_nxt = WAIT_RSP;
      WAIT_RSP: if (rsp_hit || to_hit) state_nxt = RESP;
      RESP:     if (rsp_ready_i)       state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // command latch, watchdog counter, response capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wen_q   <= 1'b0;
      add_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      // any beat outside the response window, or with a foreign ID, is stray
      stray_q <= per_r_valid_i && ((state != WAIT_RSP) || (per_r_id_i != MID));
      unique case (state)
        IDLE: if (cmd_valid_i) begin
          wen_q   <= cmd_wen_i;
          add_q   <= cmd_add_i;
          wdata_q <= cmd_wdata_i;
          be_q    <= cmd_be_i;
        end
        REQ: if (per_gnt_i) cnt <= '0;
        WAIT_RSP: begin
          if (rsp_hit) begin
            rdata_q <= wen_q ? per_r_rdata_i : 32'h0;
            err_q   <= per_r_opc_i;
            to_q    <= 1'b0;
          end else if (to_hit) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
          end else if (cnt != '1) begin
            // saturate so a disabled watchdog never wraps
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // outputs; bus fields are zero outside REQ so the bus sees a clean idle
  always_comb begin
    cmd_ready_o   = (state == IDLE);
    busy_o        = (state != IDLE);
    per_req_o     = (state == REQ);
    rsp_valid_o   = (state == RESP);
    per_add_o     = per_req_o ? add_q   : '0;
    per_wen_o     = per_req_o ? wen_q   : 1'b0;
    per_wdata_o   = per_req_o ? wdata_q : '0;
    per_be_o      = per_req_o ? be_q    : '0;
    per_id_o      = per_req_o ? MID     : '0;
    rsp_rdata_o   = rdata_q;
    rsp_err_o     = err_q;
    rsp_timeout_o = to_q;
    stray_rsp_o   = stray_q;
  end

endmodule

// File: tb/tb_periph_bus_initiator.sv
// tb_periph_bus_initiator
//   Drives directed and random transactions through periph_bus_initiator while
//   playing the bus slave. The expected cycle-by-cycle behaviour of each
//   transaction comes from a timeline built with plain arithmetic from the
//   grant delay, response delay and watchdog length.
module tb_periph_bus_initiator;
  localparam int IDW = 5;
  localparam int MID = 3;
  localparam int T   = 8;

  logic            clk_i = 1'b0, rst_ni = 1'b0;
  logic            cmd_valid_i = 0, cmd_ready_o, cmd_wen_i = 0;
  logic [31:0]     cmd_add_i = 0, cmd_wdata_i = 0;
  logic [3:0]      cmd_be_i = 0;
  logic            rsp_valid_o, rsp_ready_i = 0;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_err_o, rsp_timeout_o, busy_o, stray_rsp_o;
  logic            per_req_o, per_wen_o;
  logic [31:0]     per_add_o, per_wdata_o;
  logic [3:0]      per_be_o;
  logic [IDW-1:0]  per_id_o;
  logic            per_gnt_i = 0, per_r_valid_i = 0, per_r_opc_i = 0;
  logic [IDW-1:0]  per_r_id_i = 0;
  logic [31:0]     per_r_rdata_i = 0;

  int n_chk = 0, n_pass = 0;

  periph_bus_initiator #(.PER_ID_WIDTH(IDW), .MASTER_ID(MID), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wen_i(cmd_wen_i),
    .cmd_add_i(cmd_add_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
    .stray_rsp_o(stray_rsp_o), .per_req_o(per_req_o), .per_add_o(per_add_o),
    .per_wen_o(per_wen_o), .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
    .per_id_o(per_id_o), .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i),
    .per_r_id_i(per_r_id_i), .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},   per_req_o, 0);
    chk({tag, "_add"},   per_add_o, 0);
    chk({tag, "_wen"},   per_wen_o, 0);
    chk({tag, "_wdata"}, per_wdata_o, 0);
    chk({tag, "_be"},    per_be_o, 0);
    chk({tag, "_id"},    per_id_o, 0);
    chk({tag, "_rvld"},  rsp_valid_o, 0);
    chk({tag, "_rdata"}, rsp_rdata_o, 0);
    chk({tag, "_err"},   rsp_err_o, 0);
    chk({tag, "_tmo"},   rsp_timeout_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_stray"}, stray_rsp_o, 0);
    chk({tag, "_rdy"},   cmd_ready_o, 1);
  endtask

  task automatic slave_quiet();
    per_gnt_i = 0; per_r_valid_i = 0; per_r_id_i = 0; per_r_opc_i = 0;
    per_r_rdata_i = $urandom; rsp_ready_i = 0;
  endtask

  // g: grant wait cycles; r: response delay after grant (1..T), 0 = never
  // s_req: matching-ID beat during the first REQ cycle (must be ignored)
  // s_mid: foreign-ID beat inside the response window
  // hold: cycles rsp_ready_i stays low in RESP
  task automatic run_txn(input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                         input logic [3:0] be, input int g, input int r, input bit s_req,
                         input bit s_mid, input int hold, input logic [31:0] rd,
                         input logic opc);
    int grant_n, w, resp_at, beat_n, mid_n, stray1, stray2;
    bit tmo, done, in_req, in_resp;
    logic [31:0] e_rdata;
    logic e_err;
    grant_n = 1 + g;
    w       = 2 + g;
    tmo     = (r == 0);
    resp_at = tmo ? w + T : w + r;
    beat_n  = tmo ? -1 : 1 + g + r;
    mid_n   = !s_mid ? -1 : (tmo ? w + 1 : ((r >= 3) ? g + r - 1 : -1));
    stray1  = s_req ? 2 : -1;
    stray2  = (mid_n >= 0) ? mid_n + 1 : -1;
    e_rdata = tmo ? 32'h0 : (wen ? rd : 32'h0);
    e_err   = tmo ? 1'b1 : opc;

    @(negedge clk_i);
    chk("cmd_ready_idle", cmd_ready_o, 1);
    chk("busy_idle", busy_o, 0);
    slave_quiet();
    cmd_valid_i = 1; cmd_wen_i = wen; cmd_add_i = add; cmd_wdata_i = wdata; cmd_be_i = be;
    done = 0;
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge clk_i);
      in_req  = (n <= grant_n);
      in_resp = (n >= resp_at);
      chk("cmd_ready_busy", cmd_ready_o, 0);
      chk("busy", busy_o, 1);
      chk("per_req", per_req_o, in_req);
      if (in_req) begin
        chk("per_add", per_add_o, add);
        chk("per_wen", per_wen_o, wen);
        chk("per_wdata", per_wdata_o, wdata);
        chk("per_be", per_be_o, be);
        chk("per_id", per_id_o, MID);
      end
      chk("rsp_valid", rsp_valid_o, in_resp);
      if (in_resp) begin
        chk("rsp_rdata", rsp_rdata_o, e_rdata);
        chk("rsp_err", rsp_err_o, e_err);
        chk("rsp_timeout", rsp_timeout_o, tmo);
      end
      chk("stray", stray_rsp_o, (n == stray1 || n == stray2));
      // next-cycle stimulus; command inputs wiggle to prove they are ignored
      slave_quiet();
      cmd_valid_i = 1; cmd_wen_i = $urandom; cmd_add_i = $urandom;
      cmd_wdata_i = $urandom; cmd_be_i = 4'($urandom);
      if (n == grant_n) per_gnt_i = 1;
      if (s_req && n == 1) begin per_r_valid_i = 1; per_r_id_i = IDW'(MID); end
      if (n == mid_n)      begin per_r_valid_i = 1; per_r_id_i = 5'd5; end
      if (n == beat_n) begin
        per_r_valid_i = 1; per_r_id_i = IDW'(MID); per_r_rdata_i = rd; per_r_opc_i = opc;
      end
      if (in_resp && n >= resp_at + hold) begin rsp_ready_i = 1; done = 1; end
    end
    if (!done) chk("txn_bound", 0, 1);
  endtask

  initial begin
    bit wen, sr, sm, op;
    int g, r;
    repeat (2) @(negedge clk_i);
    chk_idle_outputs("reset");
    rst_ni = 1;

    // write, zero-wait grant, response next cycle
    run_txn(0, 32'h1000_0018, 32'h0000_1ABC, 4'hF, 0, 1, 0, 0, 0, 32'hDEAD_BEEF, 0);
    // read with 3-cycle grant delay
    run_txn(1, 32'h1000_0040, 32'h0, 4'hF, 3, 1, 0, 0, 0, 32'h1C00_0000, 0);
    // slave never responds -> watchdog
    run_txn(1, 32'h1000_0044, 32'h0, 4'hF, 0, 0, 0, 0, 0, 32'h0, 0);
    // foreign ID beat, matching beat two cycles later
    run_txn(1, 32'h1000_0048, 32'h0, 4'hF, 1, 3, 0, 1, 0, 32'h1234_5678, 0);
    // response consumer stalls 5 cycles, command held valid throughout
    run_txn(1, 32'h1000_004C, 32'h0, 4'h3, 0, 2, 0, 0, 5, 32'hA5A5_5A5A, 1);
    // matching response in the last watchdog cycle wins
    run_txn(1, 32'h1000_0050, 32'h0, 4'hF, 2, T, 1, 0, 0, 32'h0BAD_F00D, 0);

    // reset in WAIT_RSP, slave response arrives after release
    @(negedge clk_i);
    slave_quiet();
    cmd_valid_i = 1; cmd_wen_i = 1; cmd_add_i = 32'h1000_0060; cmd_be_i = 4'hF;
    @(negedge clk_i);
    cmd_valid_i = 0; per_gnt_i = 1;
    @(negedge clk_i);
    per_gnt_i = 0;
    chk("rst_busy_before", busy_o, 1);
    chk("rst_req_before", per_req_o, 0);
    #2 rst_ni = 0;
    #1 chk_idle_outputs("rst_mid");
    @(negedge clk_i);
    rst_ni = 1;
    per_r_valid_i = 1; per_r_id_i = IDW'(MID); per_r_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    per_r_valid_i = 0;
    chk("rst_late_stray", stray_rsp_o, 1);
    chk("rst_late_rvld", rsp_valid_o, 0);
    chk("rst_late_busy", busy_o, 0);
    @(negedge clk_i);
    chk("rst_stray_once", stray_rsp_o, 0);
    chk("rst_rvld_after", rsp_valid_o, 0);

    for (int i = 0; i < 40; i++) begin
      wen = 1'($urandom);
      g   = $urandom_range(0, 4);
      r   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, T);
      sr  = ($urandom_range(0, 3) == 0);
      sm  = ($urandom_range(0, 2) == 0);
      op  = ($urandom_range(0, 3) == 0);
      run_txn(wen, $urandom, $urandom, 4'($urandom), g, r, sr, sm,
              $urandom_range(0, 3), $urandom, op);
    end
    @(negedge clk_i);
    cmd_valid_i = 0;
    slave_quiet();
    repeat (2) @(negedge clk_i);
    chk("final_idle", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
